load_screen_sequencer: RTL and testbench

//  Sequences the loading-screen bar and the screen hand-over to the game.

---
 rtl/load_screen_sequencer_pkg.sv | 29 ++
 rtl/load_screen_sequencer_frame_pacer.sv | 37 +++
 rtl/load_screen_sequencer.sv | 133 +++++++++++++
 tb/tb_load_screen_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/load_screen_sequencer_pkg.sv
// Shared constants, screen/state encodings and bar geometry helper for the loading screen.
package load_screen_sequencer_pkg;

  localparam logic [9:0]  DEF_LOAD_HPOS       = 10'd260;
  localparam logic [9:0]  DEF_LOAD_BLOCK_SIZE = 10'd20;
  localparam logic [3:0]  DEF_LOAD_MAX_COUNT  = 4'd12;
  localparam int unsigned DEF_FRAMES_PER_STEP = 4;
  localparam int unsigned DEF_HOLD_FRAMES     = 30;

  typedef enum logic [1:0] {
    SCREEN_BLANK = 2'd0,
    SCREEN_LOAD  = 2'd1,
    SCREEN_GAME  = 2'd2
  } screen_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN
  } state_e;

  // Right edge of the filled part of the bar.
  function automatic logic [9:0] bar_right_edge(logic [9:0] hpos, logic [9:0] block,
                                                logic [3:0] count);
    return hpos + 10'(count) * block;
  endfunction

endpackage

// File: rtl/load_screen_sequencer_frame_pacer.sv
// Frame-tick counter with a terminal-count strobe; counts ticks 0..TERMINAL-1 and wraps.
module load_screen_sequencer_frame_pacer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned TERMINAL = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TERMINAL - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Strobe on the counted tick that reaches the terminal value.
  always_comb begin
    tc_o  = en_i && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Tick counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/load_screen_sequencer.sv
// Loading-screen sequencer: paces asset-loader steps on frame ticks, drives the bar
// fill and selects the active screen.
module load_screen_sequencer
  import load_screen_sequencer_pkg::*;
#(
  parameter logic [9:0]  LOAD_HPOS       = DEF_LOAD_HPOS,
  parameter logic [9:0]  LOAD_BLOCK_SIZE = DEF_LOAD_BLOCK_SIZE,
  parameter logic [3:0]  LOAD_MAX_COUNT  = DEF_LOAD_MAX_COUNT,
  parameter int unsigned FRAMES_PER_STEP = DEF_FRAMES_PER_STEP,
  parameter int unsigned HOLD_FRAMES     = DEF_HOLD_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       ack,
  output logic       req,
  output logic [3:0] load_counter,
  output logic [9:0] load_hpos_cval,
  output logic [1:0] screen_sel,
  output logic       load_done,
  output logic       busy
);

  state_e     state_q, state_d;
  screen_e    screen_q, screen_d;
  logic       req_q, req_d;
  logic [3:0] count_q, count_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       step_tc, hold_tc;

  // Step pacing only counts while no request is outstanding, so it freezes during a handshake.
  load_screen_sequencer_frame_pacer #(
    .WIDTH    (4),
    .TERMINAL (FRAMES_PER_STEP)
  ) u_step_pacer (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (state_q != ST_LOAD),
    .en_i   ((state_q == ST_LOAD) && !req_q && frame_tick),
    .tc_o   (step_tc)
  );

  load_screen_sequencer_frame_pacer #(
    .WIDTH    (6),
    .TERMINAL (HOLD_FRAMES)
  ) u_hold_pacer (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (state_q != ST_HOLD),
    .en_i   ((state_q == ST_HOLD) && frame_tick),
    .tc_o   (hold_tc)
  );

  // Next state, handshake and bar counter; registered outputs derive from the next state.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          count_d = '0;
          req_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (req_q) begin
          if (ack) begin
            req_d = 1'b0;
            if (count_q != LOAD_MAX_COUNT) begin
              count_d = count_q + 4'd1;
              if (count_q + 4'd1 == LOAD_MAX_COUNT) begin
                state_d = ST_HOLD;
              end
            end
          end
        end else if (step_tc) begin
          req_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (hold_tc) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (start) begin
          state_d = ST_LOAD;
          count_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    done_d = (state_q == ST_HOLD) && (state_d == ST_RUN);
    busy_d = (state_d == ST_LOAD) || (state_d == ST_HOLD);
    unique case (state_d)
      ST_IDLE: screen_d = SCREEN_BLANK;
      ST_RUN:  screen_d = SCREEN_GAME;
      default: screen_d = SCREEN_LOAD;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      screen_q <= SCREEN_BLANK;
      req_q    <= 1'b0;
      count_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      screen_q <= screen_d;
      req_q    <= req_d;
      count_q  <= count_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign req            = req_q;
  assign load_counter   = count_q;
  assign screen_sel     = screen_q;
  assign load_done      = done_q;
  assign busy           = busy_q;
  assign load_hpos_cval = bar_right_edge(LOAD_HPOS, LOAD_BLOCK_SIZE, count_q);

endmodule

// File: tb/tb_load_screen_sequencer.sv
// Self-checking bench for load_screen_sequencer: vector table, directed corner
// sequences and randomized stimulus against a behavioural model.
module tb_load_screen_sequencer;

  localparam int FPS   = 4;
  localparam int HOLDF = 30;
  localparam int MAXC  = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick, start, ack;
  logic       req;
  logic [3:0] load_counter;
  logic [9:0] load_hpos_cval;
  logic [1:0] screen_sel;
  logic       load_done, busy;

  int checks = 0;
  int errors = 0;

  load_screen_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .frame_tick     (frame_tick),
    .start          (start),
    .ack            (ack),
    .req            (req),
    .load_counter   (load_counter),
    .load_hpos_cval (load_hpos_cval),
    .screen_sel     (screen_sel),
    .load_done      (load_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 blank, 1 loading, 2 holding full bar, 3 game.
  int m_phase, m_ticks, m_blocks, m_hold;
  bit m_req, m_done;

  task automatic model_reset();
    m_phase = 0; m_ticks = 0; m_blocks = 0; m_hold = 0; m_req = 0; m_done = 0;
  endtask

  task automatic model_step(input bit st, input bit tk, input bit ak);
    m_done = 0;
    case (m_phase)
      0: if (st) begin m_phase = 1; m_blocks = 0; m_ticks = 0; m_req = 0; end
      1: begin
        if (m_req) begin
          if (ak) begin
            m_req = 0;
            m_blocks++;
            if (m_blocks == MAXC) begin m_phase = 2; m_hold = 0; end
          end
        end else if (tk) begin
          m_ticks = (m_ticks + 1) % FPS;
          if (m_ticks == 0) m_req = 1;
        end
      end
      2: if (tk) begin
        m_hold++;
        if (m_hold == HOLDF) begin m_phase = 3; m_done = 1; end
      end
      default: if (st) begin m_phase = 1; m_blocks = 0; m_ticks = 0; end
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    int exp_sel;
    exp_sel = (m_phase == 0) ? 0 : (m_phase == 3) ? 2 : 1;
    chk({tag, "_req"},  int'(req), int'(m_req));
    chk({tag, "_cnt"},  int'(load_counter), m_blocks);
    chk({tag, "_hpos"}, int'(load_hpos_cval), 260 + 20 * m_blocks);
    chk({tag, "_sel"},  int'(screen_sel), exp_sel);
    chk({tag, "_busy"}, int'(busy), int'(m_phase == 1 || m_phase == 2));
    chk({tag, "_done"}, int'(load_done), int'(m_done));
  endtask

  // One clock: drive inputs, model the edge, compare #1 after it.
  task automatic step(input bit st, input bit tk, input bit ak, input string tag);
    start = st; frame_tick = tk; ack = ak;
    @(posedge clk);
    model_step(st, tk, ak);
    #1;
    check_model(tag);
  endtask

  task automatic apply_reset();
    start = 0; frame_tick = 0; ack = 0;
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_req",  int'(req), 0);
    chk("rst_cnt",  int'(load_counter), 0);
    chk("rst_sel",  int'(screen_sel), 0);
    chk("rst_hpos", int'(load_hpos_cval), 260);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(load_done), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Tick until req rises; returns number of ticks used (bounded).
  task automatic pace_to_req(output int n);
    n = 0;
    while (!req && n < 64) begin
      step(0, 1, 0, "pace");
      n++;
    end
    if (!req) chk("req_timeout", 0, 1);
  endtask

  task automatic load_block(input int ack_delay);
    int n;
    pace_to_req(n);
    chk("ticks_per_req", n, FPS);
    repeat (ack_delay) step(0, 0, 0, "ackwait");
    step(0, 0, 1, "ack");
  endtask

  typedef struct {
    bit st, tk, ak;
    bit req;
    int cnt, sel;
    bit busy, done;
  } vec_t;

  function automatic vec_t mk(bit st, bit tk, bit ak, bit r, int c, int s, bit b);
    vec_t v;
    v.st = st; v.tk = tk; v.ak = ak; v.req = r; v.cnt = c; v.sel = s; v.busy = b; v.done = 0;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    int   n;
    reset = 1'b0; start = 0; frame_tick = 0; ack = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check_model("por");

    // Vector table from IDLE: spurious ack, start+tick, pacing, tick coincident with
    // ack, long ack, start ignored in LOAD.
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 2, 1, 1));
    foreach (tbl[i]) begin
      step(tbl[i].st, tbl[i].tk, tbl[i].ak, "vec");
      chk($sformatf("tbl%0d_req", i),  int'(req), int'(tbl[i].req));
      chk($sformatf("tbl%0d_cnt", i),  int'(load_counter), tbl[i].cnt);
      chk($sformatf("tbl%0d_hpos", i), int'(load_hpos_cval), 260 + 20 * tbl[i].cnt);
      chk($sformatf("tbl%0d_sel", i),  int'(screen_sel), tbl[i].sel);
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i), int'(load_done), int'(tbl[i].done));
    end

    // Reset mid-LOAD with req outstanding: outputs clear at once.
    pace_to_req(n);
    chk("pre_reset_req", int'(req), 1);
    apply_reset();

    // Full load with ack two cycles after each req, then the hold and the hand-over.
    step(1, 0, 0, "start");
    for (int b = 0; b < MAXC; b++) begin
      load_block(2);
      chk("full_cnt", int'(load_counter), b + 1);
    end
    chk("full_hpos", int'(load_hpos_cval), 500);
    chk("full_sel_hold", int'(screen_sel), 1);
    step(0, 0, 1, "ack_in_hold");
    chk("hold_cnt_sat", int'(load_counter), MAXC);
    for (int t = 0; t < HOLDF - 1; t++) step(0, 1, 0, "hold");
    chk("hold_still_load", int'(screen_sel), 1);
    step(0, 1, 0, "hold_end");
    chk("run_done", int'(load_done), 1);
    chk("run_sel", int'(screen_sel), 2);
    chk("run_busy", int'(busy), 0);
    step(0, 1, 0, "run");
    chk("done_one_cycle", int'(load_done), 0);

    // Start in RUN restarts loading from an empty bar.
    step(1, 0, 0, "restart");
    chk("restart_cnt", int'(load_counter), 0);
    chk("restart_sel", int'(screen_sel), 1);

    // Slow ack: three frames with req high; pacing frozen, one step counted.
    pace_to_req(n);
    for (int f = 0; f < 3; f++) begin
      repeat (3) step(0, 0, 0, "slow_gap");
      step(0, 1, 0, "slow_tick");
      chk("slow_req_held", int'(req), 1);
    end
    step(0, 0, 1, "slow_ack");
    chk("slow_cnt", int'(load_counter), 1);
    for (int b = 1; b < 5; b++) load_block(1);
    chk("cnt5", int'(load_counter), 5);
    step(1, 0, 0, "start_in_load");
    chk("start_ignored_cnt", int'(load_counter), 5);
    chk("start_ignored_sel", int'(screen_sel), 1);
    load_block(0);
    chk("after_ignore_cnt", int'(load_counter), 6);

    // Randomized traffic against the model, with an occasional asynchronous reset.
    apply_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) apply_reset();
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
